// File: rtl/uart_apb_tx_scheduler.sv
// rtl/uart_apb_tx_scheduler.sv - APB master that configures a UART and round-robins requester bytes into its transmitter
module uart_apb_tx_scheduler #(
    parameter int          NUM_REQ  = 4,
    parameter logic [7:0]  BAUD_LO  = 8'd0,
    parameter logic [7:0]  CTRL2    = 8'h01,
    parameter logic [2:0]  CTRL3    = 3'd0,
    parameter int          POLL_GAP = 2,
    localparam int         GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 cfg_done,
    output logic [4:0]           m_PADDR,
    output logic                 m_PSEL,
    output logic                 m_PENABLE,
    output logic                 m_PWRITE,
    output logic [7:0]           m_PWDATA,
    input  logic [7:0]           m_PRDATA,
    input  logic                 m_PREADY
);

    typedef enum logic [2:0] {
        S_CFG1, S_CFG2, S_CFG3, S_IDLE, S_POLL, S_GAP, S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE, PH_SETUP, PH_ACCESS
    } phase_t;

    state_t          state, state_n;
    phase_t          phase, phase_n;
    logic [3:0]      gap_cnt, gap_n;
    logic [GW-1:0]   ptr;
    logic [7:0]      data_q;
    logic            xfer_done;
    logic            grant;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic [GW:0]     cand;
    logic            apb_sel;
    logic            unused_status;

    // Only TXRDY is interpreted; error and other status bits are deliberately dropped.
    assign unused_status = ^m_PRDATA[7:1];

    assign xfer_done = (phase == PH_ACCESS) && m_PREADY;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ))
                cand = cand - (GW+1)'(NUM_REQ);
            if (!pick_valid && req_valid[cand[GW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[GW-1:0];
            end
        end
    end

    assign grant = (state == S_IDLE) && pick_valid;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[pick_idx] = 1'b1;
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        gap_n   = gap_cnt;
        if (phase == PH_SETUP)
            phase_n = PH_ACCESS;
        case (state)
            S_CFG1: begin
                if (phase == PH_NONE) begin
                    phase_n = PH_SETUP;
                end else if (xfer_done) begin
                    state_n = S_CFG2;
                    phase_n = PH_SETUP;
                end
            end
            S_CFG2: begin
                if (xfer_done) begin
                    state_n = S_CFG3;
                    phase_n = PH_SETUP;
                end
            end
            S_CFG3: begin
                if (xfer_done) begin
                    state_n = S_IDLE;
                    phase_n = PH_NONE;
                end
            end
            S_IDLE: begin
                if (pick_valid) begin
                    state_n = S_POLL;
                    phase_n = PH_SETUP;
                end
            end
            S_POLL: begin
                if (xfer_done) begin
                    if (m_PRDATA[0]) begin
                        state_n = S_WRITE;
                        phase_n = PH_SETUP;
                    end else if (POLL_GAP == 0) begin
                        phase_n = PH_SETUP;
                    end else begin
                        state_n = S_GAP;
                        phase_n = PH_NONE;
                        gap_n   = 4'(POLL_GAP - 1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_n = S_POLL;
                    phase_n = PH_SETUP;
                end else begin
                    gap_n = gap_cnt - 4'd1;
                end
            end
            S_WRITE: begin
                if (xfer_done) begin
                    state_n = S_IDLE;
                    phase_n = PH_NONE;
                end
            end
            default: begin
                state_n = S_CFG1;
                phase_n = PH_NONE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state    <= S_CFG1;
            phase    <= PH_NONE;
            gap_cnt  <= 4'd0;
            ptr      <= '0;
            grant_id <= '0;
            data_q   <= 8'd0;
            cfg_done <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            gap_cnt <= gap_n;
            if (grant) begin
                grant_id <= pick_idx;
                data_q   <= req_data[{pick_idx, 3'b000} +: 8];
            end
            if (state == S_WRITE && xfer_done) begin
                if (grant_id == GW'(NUM_REQ - 1))
                    ptr <= '0;
                else
                    ptr <= grant_id + 1'b1;
            end
            if (state == S_CFG3 && xfer_done)
                cfg_done <= 1'b1;
        end
    end

    // Bus outputs decode straight from registered state so reset drops them at once.
    assign apb_sel = (phase != PH_NONE);

    always_comb begin
        m_PSEL    = apb_sel;
        m_PENABLE = (phase == PH_ACCESS);
        m_PWRITE  = 1'b0;
        m_PADDR   = 5'h00;
        m_PWDATA  = 8'h00;
        if (apb_sel) begin
            case (state)
                S_CFG1: begin
                    m_PWRITE = 1'b1;
                    m_PADDR  = 5'h08;
                    m_PWDATA = BAUD_LO;
                end
                S_CFG2: begin
                    m_PWRITE = 1'b1;
                    m_PADDR  = 5'h0C;
                    m_PWDATA = CTRL2;
                end
                S_CFG3: begin
                    m_PWRITE = 1'b1;
                    m_PADDR  = 5'h14;
                    m_PWDATA = {5'b00000, CTRL3};
                end
                S_POLL: begin
                    m_PADDR = 5'h10;
                end
                S_WRITE: begin
                    m_PWRITE = 1'b1;
                    m_PADDR  = 5'h00;
                    m_PWDATA = data_q;
                end
                default: begin
                    m_PADDR = 5'h00;
                end
            endcase
        end
    end

    assign busy = (state == S_POLL) || (state == S_GAP) || (state == S_WRITE);

endmodule

// File: tb/tb_uart_apb_tx_scheduler.sv
// tb/tb_uart_apb_tx_scheduler.sv - directed self-checking bench for uart_apb_tx_scheduler
module tb_uart_apb_tx_scheduler;

    localparam int N = 4;

    logic           PCLK = 1'b0;
    logic           PRESETN = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           cfg_done;
    logic [4:0]     m_PADDR;
    logic           m_PSEL;
    logic           m_PENABLE;
    logic           m_PWRITE;
    logic [7:0]     m_PWDATA;
    logic [7:0]     m_PRDATA;
    logic           m_PREADY;

    uart_apb_tx_scheduler #(
        .NUM_REQ(N), .BAUD_LO(8'd0), .CTRL2(8'h01), .CTRL3(3'd0), .POLL_GAP(2)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .busy(busy), .cfg_done(cfg_done),
        .m_PADDR(m_PADDR), .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE),
        .m_PWRITE(m_PWRITE), .m_PWDATA(m_PWDATA),
        .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } xfer_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;

    xfer_t log_q[$];
    int    en_q[$];
    int    cyc;
    int    wait_cnt = 0;
    int    poll_count = 0;
    int    ready_pulses = 0;
    int    stab_err = 0;
    int    en_run = 0;
    logic [4:0] cap_addr = '0;
    logic [7:0] cap_data = '0;
    logic       cap_wr = 1'b0;
    int    stall = 0;
    int    rdy_after = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    // Simple UART slave: programmable wait states, TXRDY after a set number of polls, error bits set.
    assign m_PREADY = !(m_PSEL && m_PENABLE) || (wait_cnt >= stall);
    assign m_PRDATA = {3'b000, 3'b111, 1'b0, (poll_count >= rdy_after)};

    always @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) cyc <= 0;
        else          cyc <= cyc + 1;

    always @(posedge PCLK) begin
        if (m_PSEL && m_PENABLE && !m_PREADY) wait_cnt <= wait_cnt + 1;
        else                                  wait_cnt <= 0;
        if (req_ready != '0) ready_pulses <= ready_pulses + 1;
        if (PRESETN && m_PSEL && m_PENABLE && m_PREADY) begin
            log_q.push_back('{wr: m_PWRITE, addr: m_PADDR, data: m_PWDATA, cyc: cyc});
            if (!m_PWRITE) poll_count <= poll_count + 1;
        end
        if (m_PSEL && !m_PENABLE) begin
            cap_addr <= m_PADDR;
            cap_data <= m_PWDATA;
            cap_wr   <= m_PWRITE;
            en_run   <= 0;
        end else if (m_PSEL && m_PENABLE) begin
            if (m_PADDR != cap_addr || m_PWDATA != cap_data || m_PWRITE != cap_wr)
                stab_err <= stab_err + 1;
            en_run <= en_run + 1;
            if (m_PREADY) en_q.push_back(en_run + 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic grant_req(input logic [3:0] valid, input logic [31:0] data,
                             input logic [3:0] exp_ready, input logic [1:0] exp_gid);
        int k;
        req_valid = valid;
        req_data  = data;
        #1;
        k = 0;
        while (req_ready == '0 && k < 40) begin
            tick;
            k++;
        end
        check("grant_ready", req_ready, exp_ready);
        tick;
        req_valid = '0;
        check("grant_id", grant_id, exp_gid);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick;
            k++;
        end
        check("busy_timeout", busy, 1'b0);
    endtask

    function automatic int count_wr0(input int from);
        int n;
        n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].wr && log_q[i].addr == 5'h00) n++;
        return n;
    endfunction

    function automatic logic [7:0] last_wr0_data(input int from);
        logic [7:0] d;
        d = 8'hxx;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].wr && log_q[i].addr == 5'h00) d = log_q[i].data;
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    int   base, pbase, ebase, rd_n, k;
    int   rd_cyc[$];
    logic [4:0] exp_addr[3];
    logic [7:0] exp_data[3];
    int         exp_cyc[3];

    initial begin
        vecs[0] = '{4'b0011, 32'h4433_2211, 4'b0001, 2'd0, 8'h11};
        vecs[1] = '{4'b1010, 32'h8877_6655, 4'b0010, 2'd1, 8'h66};
        vecs[2] = '{4'b1010, 32'hCCBB_AA99, 4'b1000, 2'd3, 8'hCC};
        vecs[3] = '{4'b1111, 32'h0403_0201, 4'b0001, 2'd0, 8'h01};
        vecs[4] = '{4'b0001, 32'hDEAD_BEEF, 4'b0001, 2'd0, 8'hEF};
        vecs[5] = '{4'b1100, 32'h1234_5678, 4'b0100, 2'd2, 8'h34};
        vecs[6] = '{4'b1100, 32'h1234_5678, 4'b1000, 2'd3, 8'h12};
        exp_addr = '{5'h08, 5'h0C, 5'h14};
        exp_data = '{8'h00, 8'h01, 8'h00};
        exp_cyc  = '{2, 4, 6};

        req_valid = '0;
        req_data  = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_psel", m_PSEL, 1'b0);
        check("rst_penable", m_PENABLE, 1'b0);
        check("rst_paddr", m_PADDR, 5'h00);
        check("rst_pwdata", m_PWDATA, 8'h00);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);

        // Configuration sequence, PREADY always high
        base = log_q.size();
        PRESETN = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (c == 1) check("cfg1_setup", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR}, {3'b101, 5'h08});
            if (c == 3) begin
                req_valid = 4'b0001;
                #1;
                check("ready_before_cfg", req_ready, 4'b0000);
            end
            if (c == 4) req_valid = '0;
            if (c == 6) check("cfg_done_c6", cfg_done, 1'b0);
        end
        check("cfg_done_c7", cfg_done, 1'b1);
        check("cfg_count", log_q.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < log_q.size()) begin
                check("cfg_addr", log_q[base+i].addr, exp_addr[i]);
                check("cfg_data", log_q[base+i].data, exp_data[i]);
                check("cfg_cyc", log_q[base+i].cyc, exp_cyc[i]);
            end
        end

        // Best-case single byte, cycle by cycle
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        #1;
        check("b0_ready", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        check("b1_poll_setup", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR}, {3'b100, 5'h10});
        check("b1_busy", busy, 1'b1);
        check("b1_gid", grant_id, 2'd2);
        tick;
        check("b2_poll_access", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR}, {3'b110, 5'h10});
        tick;
        check("b3_wr_setup", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA}, {3'b101, 5'h00, 8'hA5});
        tick;
        check("b4_wr_access", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA}, {3'b111, 5'h00, 8'hA5});
        check("b4_busy", busy, 1'b1);
        tick;
        check("b5_busy", busy, 1'b0);
        check("b5_psel", m_PSEL, 1'b0);

        // Round-robin vector table
        for (int v = 0; v < 7; v++) begin
            base = log_q.size();
            grant_req(vecs[v].valid, vecs[v].data, vecs[v].exp_ready, vecs[v].exp_gid);
            wait_idle(40);
            check("vec_writes", count_wr0(base), 1);
            check("vec_byte", last_wr0_data(base), vecs[v].exp_byte);
        end

        // Three not-ready polls before TXRDY
        base  = log_q.size();
        pbase = ready_pulses;
        rdy_after = poll_count + 3;
        grant_req(4'b0010, 32'h0000_5A00, 4'b0010, 2'd1);
        wait_idle(80);
        rd_cyc.delete();
        for (int i = base; i < log_q.size(); i++)
            if (!log_q[i].wr) rd_cyc.push_back(log_q[i].cyc);
        rd_n = rd_cyc.size();
        check("poll_reads", rd_n, 4);
        for (int i = 1; i < rd_n; i++)
            check("poll_spacing", rd_cyc[i] - rd_cyc[i-1], 4);
        check("poll_writes", count_wr0(base), 1);
        check("poll_byte", last_wr0_data(base), 8'h5A);
        check("poll_pulses", ready_pulses - pbase, 1);
        rdy_after = 0;

        // Wait states in every ACCESS
        stall = 3;
        base  = log_q.size();
        ebase = en_q.size();
        grant_req(4'b1000, 32'h7700_0000, 4'b1000, 2'd3);
        wait_idle(80);
        check("ws_transfers", en_q.size() - ebase, 2);
        for (int i = ebase; i < en_q.size(); i++)
            check("ws_enable_len", en_q[i], 4);
        check("ws_stable", stab_err, 0);
        check("ws_byte", last_wr0_data(base), 8'h77);
        stall = 0;

        // Reset asserted during a stalled write ACCESS
        stall = 20;
        grant_req(4'b0001, 32'h0000_00C3, 4'b0001, 2'd0);
        k = 0;
        while (!(m_PSEL && m_PENABLE && m_PWRITE) && k < 40) begin
            tick;
            k++;
        end
        check("rst_mid_found", {m_PSEL, m_PENABLE, m_PWRITE}, 3'b111);
        tick;
        #2;
        PRESETN = 1'b0;
        #1;
        check("mid_rst_bus", {m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA}, 16'h0000);
        check("mid_rst_state", {busy, cfg_done, req_ready}, 6'b000000);
        base  = log_q.size();
        stall = 0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETN = 1'b1;
        repeat (7) tick;
        check("recfg_done", cfg_done, 1'b1);
        check("recfg_count", log_q.size() - base, 3);
        for (int i = 0; i < 3; i++)
            if (base + i < log_q.size())
                check("recfg_addr", log_q[base+i].addr, exp_addr[i]);
        check("total_data_writes", count_wr0(0), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
